// File: rtl/dmem_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bus between a load/store initiator and the data memory
// responder. Clock and reset are not part of the bundle.
//
// Signals:
//   req_valid  initiator -> responder  request present
//   req_ready  responder -> initiator  responder can accept a request
//   req_write  initiator -> responder  1 = store, 0 = load
//   req_addr   initiator -> responder  8-bit word address
//   req_wdata  initiator -> responder  32-bit store data
//   rsp_valid  responder -> initiator  response present
//   rsp_ready  initiator -> responder  initiator accepts the response
//   rsp_rdata  responder -> initiator  32-bit load data (0 for stores)
//   rsp_err    responder -> initiator  access was out of range
// Modports: master (initiator side), slave (responder side).
// ----------------------------------------------------------------------------
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Single-port word memory answering one load/store at a time over a
// valid/ready request channel and a valid/ready response channel. Each
// access spends WAIT_CYCLES extra wait states before the response appears.
//
// Parameters:
//   DEPTH        number of 32-bit words (1..256)
//   WAIT_CYCLES  extra wait states per access (0..15)
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    dmem_responder_if.slave (request and response channels)
// Build option:
//   DMEM_BOUNDS_CHECK_EN  when defined, addresses >= DEPTH raise rsp_err,
//                         suppress stores and return 0 for loads; when not
//                         defined, addresses wrap modulo DEPTH and rsp_err
//                         is tied to 0.
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_V   = 9'(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic [3:0]      cnt_nxt;

    logic            cap_write;
    logic [7:0]      cap_addr;
    logic [31:0]     cap_wdata;

    logic            op_write;
    logic [7:0]      op_addr;
    logic [31:0]     op_wdata;
    logic            in_range;
    logic [AW-1:0]   idx;

    logic            accept;
    logic            enter_resp;
    logic [31:0]     rdata;
    logic [31:0]     mem [DEPTH];

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bus.req_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = WAIT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept     = (state == IDLE) && bus.req_valid;
    assign enter_resp = (state != RESP) && (state_nxt == RESP);

    // With zero wait states the memory operation happens on the accept edge
    // itself, before the capture registers hold the request, so the live
    // request fields are used while still in IDLE.
    always_comb begin
        if (state == IDLE) begin
            op_write = bus.req_write;
            op_addr  = bus.req_addr;
            op_wdata = bus.req_wdata;
        end else begin
            op_write = cap_write;
            op_addr  = cap_addr;
            op_wdata = cap_wdata;
        end
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    assign in_range = ({1'b0, op_addr} < DEPTH_V);
    assign idx      = op_addr[AW-1:0];
`else
    assign in_range = 1'b1;
    assign idx      = AW'({1'b0, op_addr} % DEPTH_V);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rdata <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (enter_resp) begin
                rdata <= (!op_write && in_range) ? mem[idx] : 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_write <= bus.req_write;
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
        end
    end

    // Stores commit only on the edge entering RESP, so a reset while BUSY
    // abandons them; the array itself is never cleared.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && op_write && in_range) begin
            mem[idx] <= op_wdata;
        end
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    logic err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (enter_resp) begin
            err <= !in_range;
        end
    end

    assign bus.rsp_err = err;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
// Two responders (zero and two wait states) driven from a common clock,
// checked every cycle against a timestamp-based model of the memory and the
// response timing, plus directed scenarios with literal expectations.
// ----------------------------------------------------------------------------
module tb_dmem_responder;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_t   [2];
    logic        reqv    [2];
    logic        reqw    [2];
    logic        rspr    [2];
    logic [7:0]  reqa    [2];
    logic [31:0] reqd    [2];
    logic        rdy_o   [2];
    logic        vld_o   [2];
    logic        err_o   [2];
    logic [31:0] rdata_o [2];

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    assign bus0.req_valid = reqv[0];
    assign bus0.req_write = reqw[0];
    assign bus0.req_addr  = reqa[0];
    assign bus0.req_wdata = reqd[0];
    assign bus0.rsp_ready = rspr[0];
    assign rdy_o[0]       = bus0.req_ready;
    assign vld_o[0]       = bus0.rsp_valid;
    assign rdata_o[0]     = bus0.rsp_rdata;
    assign err_o[0]       = bus0.rsp_err;

    assign bus1.req_valid = reqv[1];
    assign bus1.req_write = reqw[1];
    assign bus1.req_addr  = reqa[1];
    assign bus1.req_wdata = reqd[1];
    assign bus1.rsp_ready = rspr[1];
    assign rdy_o[1]       = bus1.req_ready;
    assign vld_o[1]       = bus1.rsp_valid;
    assign rdata_o[1]     = bus1.rsp_rdata;
    assign err_o[1]       = bus1.rsp_err;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .reset (rst_t[0]),
        .bus   (bus0)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut1 (
        .clk   (clk),
        .reset (rst_t[1]),
        .bus   (bus1)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en [2];

    function automatic int wait_of(input int u);
        return (u == 0) ? 0 : 2;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur within its cycle budget (t=%0t)", nm, $time);
    endtask

    // Behavioural model: a request is taken when nothing is outstanding; its
    // result becomes visible once W edges have passed since the accept edge
    // (so the initiator samples rsp_valid at the (W+1)-th edge) and stays
    // until a handshake edge.
    bit          pend [2];
    bit          ev   [2];
    int          acc  [2];
    bit          ow   [2];
    logic [7:0]  oa   [2];
    logic [31:0] od   [2];
    logic [31:0] erd  [2];
    logic        eerr [2];
    logic [31:0] mdl_mem [2][DEPTH];

    always @(posedge clk) begin : model
        int ix;
        bit oob;
        cyc++;
        for (int u = 0; u < 2; u++) begin
            if (!rst_t[u]) begin
                pend[u] = 1'b0;
                ev[u]   = 1'b0;
            end else begin
                if (pend[u] && ev[u]) begin
                    if (rspr[u]) begin
                        pend[u] = 1'b0;
                        ev[u]   = 1'b0;
                    end
                end else if (!pend[u] && reqv[u]) begin
                    pend[u] = 1'b1;
                    acc[u]  = cyc;
                    ow[u]   = reqw[u];
                    oa[u]   = reqa[u];
                    od[u]   = reqd[u];
                end
                if (pend[u] && !ev[u] && (cyc - acc[u] == wait_of(u))) begin
                    ix  = int'(oa[u]) % DEPTH;
                    oob = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
                    oob = (int'(oa[u]) >= DEPTH);
`endif
                    eerr[u] = oob;
                    if (oob) begin
                        erd[u] = 32'd0;
                    end else if (ow[u]) begin
                        mdl_mem[u][ix] = od[u];
                        erd[u] = 32'd0;
                    end else begin
                        erd[u] = mdl_mem[u][ix];
                    end
                    ev[u] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (chk_en[u]) begin
                check($sformatf("dut%0d req_ready", u), 32'(rdy_o[u]), 32'(!pend[u]));
                check($sformatf("dut%0d rsp_valid", u), 32'(vld_o[u]), 32'(ev[u]));
                if (ev[u]) begin
                    check($sformatf("dut%0d rsp_rdata", u), rdata_o[u], erd[u]);
                    check($sformatf("dut%0d rsp_err", u), 32'(err_o[u]), 32'(eerr[u]));
                end
            end
        end
    end

    // One complete access. lat = number of edges after the accept edge up to
    // and including the first edge that samples rsp_valid=1. stable reports
    // whether the response and req_ready=0 held during the hold cycles.
    task automatic access(input int u, input bit w, input logic [7:0] a, input logic [31:0] d,
                          input int hold, output logic [31:0] rd, output logic er,
                          output int lat, output bit stable);
        int g;
        @(negedge clk);
        reqw[u] = w;
        reqa[u] = a;
        reqd[u] = d;
        reqv[u] = 1'b1;
        rspr[u] = 1'b0;
        g = 0;
        while (!rdy_o[u] && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) timeout($sformatf("dut%0d accept", u));
        @(posedge clk);
        @(negedge clk);
        reqv[u] = 1'b0;
        reqw[u] = ~w;
        reqa[u] = a ^ 8'h01;
        reqd[u] = d ^ 32'h33;
        lat = 1;
        while (!vld_o[u] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!vld_o[u]) timeout($sformatf("dut%0d response", u));
        rd = rdata_o[u];
        er = err_o[u];
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!vld_o[u] || rdata_o[u] !== rd || err_o[u] !== er || rdy_o[u] !== 1'b0)
                stable = 1'b0;
        end
        rspr[u] = 1'b1;
        @(negedge clk);
        rspr[u] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at t=%0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          st;
        int          g;
        int          t;
        int          prev;
        bit          seen;

        for (int u = 0; u < 2; u++) begin
            rst_t[u]  = 1'b0;
            reqv[u]   = 1'b0;
            reqw[u]   = 1'b0;
            reqa[u]   = 8'd0;
            reqd[u]   = 32'd0;
            rspr[u]   = 1'b0;
            pend[u]   = 1'b0;
            ev[u]     = 1'b0;
            erd[u]    = 32'd0;
            eerr[u]   = 1'b0;
            chk_en[u] = 1'b0;
            for (int i = 0; i < DEPTH; i++) mdl_mem[u][i] = 32'd0;
        end

        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("dut%0d reset req_ready", u), 32'(rdy_o[u]), 32'd1);
            check($sformatf("dut%0d reset rsp_valid", u), 32'(vld_o[u]), 32'd0);
            check($sformatf("dut%0d reset rsp_rdata", u), rdata_o[u], 32'd0);
            check($sformatf("dut%0d reset rsp_err", u), 32'(err_o[u]), 32'd0);
            rst_t[u]  = 1'b1;
            chk_en[u] = 1'b1;
        end

        // Give every word a known value of zero.
        for (int u = 0; u < 2; u++)
            for (int a = 0; a < DEPTH; a++)
                access(u, 1'b1, 8'(a), 32'd0, 0, rd, er, lat, st);

        // Store then load, two wait states.
        access(1, 1'b1, 8'd5, 32'hDEADBEEF, 0, rd, er, lat, st);
        check("w2 store latency", 32'(lat), 32'd3);
        check("w2 store rdata", rd, 32'd0);
        access(1, 1'b0, 8'd5, 32'd0, 0, rd, er, lat, st);
        check("w2 load latency", 32'(lat), 32'd3);
        check("w2 load rdata", rd, 32'hDEADBEEF);
        check("w2 load err", 32'(er), 32'd0);

        // Zero wait states, response held 4 cycles.
        access(0, 1'b1, 8'd5, 32'h0BADF00D, 0, rd, er, lat, st);
        check("w0 store latency", 32'(lat), 32'd1);
        access(0, 1'b0, 8'd5, 32'd0, 4, rd, er, lat, st);
        check("w0 load latency", 32'(lat), 32'd1);
        check("w0 load rdata", rd, 32'h0BADF00D);
        check("w0 response held stable", 32'(st), 32'd1);
        check("w0 idle after handshake", 32'(rdy_o[0]), 32'd1);

        // Request fields change after accept (the task flips them).
        access(1, 1'b1, 8'd3, 32'h11, 1, rd, er, lat, st);
        access(1, 1'b0, 8'd3, 32'd0, 0, rd, er, lat, st);
        check("capture load rdata", rd, 32'h11);

        // Reset one edge after accepting a store.
        @(negedge clk);
        reqw[1] = 1'b1;
        reqa[1] = 8'd7;
        reqd[1] = 32'hAAAA5555;
        reqv[1] = 1'b1;
        g = 0;
        while (!rdy_o[1] && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        @(negedge clk);
        reqv[1]  = 1'b0;
        rst_t[1] = 1'b0;
        @(negedge clk);
        rst_t[1] = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (vld_o[1]) seen = 1'b1;
        end
        check("busy reset no response", 32'(seen), 32'd0);
        access(1, 1'b0, 8'd7, 32'd0, 0, rd, er, lat, st);
        check("busy reset store dropped", rd, 32'd0);

        // Request presented while reset is low is ignored.
        access(0, 1'b1, 8'd9, 32'h12345678, 0, rd, er, lat, st);
        @(negedge clk);
        rst_t[0] = 1'b0;
        reqw[0]  = 1'b1;
        reqa[0]  = 8'd9;
        reqd[0]  = 32'h00000BAD;
        reqv[0]  = 1'b1;
        @(negedge clk);
        check("reset req not accepted ready", 32'(rdy_o[0]), 32'd1);
        check("reset req not accepted valid", 32'(vld_o[0]), 32'd0);
        rst_t[0] = 1'b1;
        reqv[0]  = 1'b0;
        access(0, 1'b0, 8'd9, 32'd0, 0, rd, er, lat, st);
        check("reset req store dropped", rd, 32'h12345678);

        // Out-of-range address 70 with DEPTH 64.
        access(1, 1'b1, 8'd70, 32'hCAFEF00D, 0, rd, er, lat, st);
        check("oob store latency", 32'(lat), 32'd3);
`ifdef DMEM_BOUNDS_CHECK_EN
        check("oob store err", 32'(er), 32'd1);
        access(1, 1'b0, 8'd6, 32'd0, 0, rd, er, lat, st);
        check("oob word 6 untouched", rd, 32'd0);
        access(1, 1'b0, 8'd70, 32'd0, 0, rd, er, lat, st);
        check("oob load rdata", rd, 32'd0);
        check("oob load err", 32'(er), 32'd1);
`else
        check("wrap store err", 32'(er), 32'd0);
        access(1, 1'b0, 8'd6, 32'd0, 0, rd, er, lat, st);
        check("wrap word 6 written", rd, 32'hCAFEF00D);
        check("wrap load err", 32'(er), 32'd0);
`endif

        // Throughput: valid and ready held high, store/load pairs.
        rspr[1] = 1'b1;
        prev = 0;
        for (int k = 0; k < 20; k++) begin
            g = 0;
            while (!rdy_o[1] && g < 20) begin
                @(negedge clk);
                g++;
            end
            if (g >= 20) timeout("throughput accept");
            reqw[1] = (k % 2 == 0);
            reqa[1] = 8'(10 + k / 2);
            reqd[1] = (k % 2 == 0) ? $urandom : 32'd0;
            reqv[1] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            t = cyc;
            if (k > 0) check("throughput accept spacing", 32'(t - prev), 32'd4);
            prev = t;
        end
        reqv[1] = 1'b0;
        repeat (8) @(negedge clk);
        rspr[1] = 1'b0;

        // Randomized accesses, including out-of-range addresses.
        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 60; n++) begin
                access(u, 1'($urandom_range(0, 1)), 8'($urandom_range(0, DEPTH + 15)),
                       $urandom, int'($urandom_range(0, 2)), rd, er, lat, st);
                check($sformatf("dut%0d random latency", u), 32'(lat), 32'(wait_of(u) + 1));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
